// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// Master drives the binary value and consumes the BCD result.
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  ovf;

   modport master (
      output in_valid,
      output bin_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bcd_out,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  bin_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bcd_out,
      output ovf
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter, one input bit per clock.
// Result register is separate from the working accumulator.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic           clk,
   input  logic           rst,
   bin2bcd_seq_if.slave   bus
);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [BW-1:0]     acc_q, acc_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              sov_q, sov_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              ovf_q, ovf_d;

   logic [BW-1:0]     adj;
   logic [BW-1:0]     acc_sh;
   logic [BIN_W-1:0]  bin_sh;
   logic              carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sov_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sov_q   <= sov_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sov_d   = sov_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;

      // +3 on every nibble >= 5, top digit included
      adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      {carry, acc_sh, bin_sh} = {adj, bin_q, 1'b0};

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               bin_d   = bus.bin_in;
               acc_d   = '0;
               sov_d   = 1'b0;
               cnt_d   = 6'(BIN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bin_d = bin_sh;
            acc_d = acc_sh;
            sov_d = sov_q | carry;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               bcd_d   = acc_sh;
               ovf_d   = sov_q | carry;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.bcd_out   = bcd_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks for bin2bcd_seq in three
// width/digit configurations.
module tb_bin2bcd_seq;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if0 ();
   bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if1 ();
   bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if2 ();

   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u0 (
      .clk (clk), .rst (rst), .bus (if0)
   );
   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u1 (
      .clk (clk), .rst (rst), .bus (if1)
   );
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u2 (
      .clk (clk), .rst (rst), .bus (if2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic [31:0] bin;
      logic [31:0] bcd;
      logic        ovf;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void refm(input int v, input int d,
                                output logic [31:0] b, output logic o);
      b = '0;
      for (int i = 0; i < d; i++) begin
         b[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      o = (v != 0);
   endfunction

   task automatic conv0(input logic [31:0] v, output logic [31:0] b,
                        output logic o, output int lat);
      @(negedge clk);
      if0.in_valid = 1'b1;
      if0.bin_in   = v[7:0];
      @(negedge clk);
      if0.in_valid = 1'b0;
      lat = 0;
      while (!if0.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      b = 32'(if0.bcd_out);
      o = if0.ovf;
      @(negedge clk);
   endtask

   task automatic conv1(input logic [31:0] v, output logic [31:0] b,
                        output logic o, output int lat);
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.bin_in   = v[15:0];
      @(negedge clk);
      if1.in_valid = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      b = 32'(if1.bcd_out);
      o = if1.ovf;
      @(negedge clk);
   endtask

   task automatic conv2(input logic [31:0] v, output logic [31:0] b,
                        output logic o, output int lat);
      @(negedge clk);
      if2.in_valid = 1'b1;
      if2.bin_in   = v[7:0];
      @(negedge clk);
      if2.in_valid = 1'b0;
      lat = 0;
      while (!if2.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      b = 32'(if2.bcd_out);
      o = if2.ovf;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      logic [31:0] b;
      logic        o;
      int          lat;
      int          wl;
      logic [7:0]  q[$];
      int          sent;
      int          got;
      int          cyc;
      logic        drop;
      logic [7:0]  e;
      logic [31:0] eb;
      logic        eo;

      total = 0;
      bad   = 0;

      tbl.push_back('{0, 255,   32'h255,   1'b0, 8});
      tbl.push_back('{0, 0,     32'h000,   1'b0, 8});
      tbl.push_back('{0, 99,    32'h099,   1'b0, 8});
      tbl.push_back('{0, 10,    32'h010,   1'b0, 8});
      tbl.push_back('{1, 65535, 32'h65535, 1'b0, 16});
      tbl.push_back('{1, 10000, 32'h10000, 1'b0, 16});
      tbl.push_back('{1, 1,     32'h00001, 1'b0, 16});
      tbl.push_back('{2, 200,   32'h00,    1'b1, 8});
      tbl.push_back('{2, 99,    32'h99,    1'b0, 8});
      tbl.push_back('{2, 123,   32'h23,    1'b1, 8});

      rst = 1'b1;
      if0.in_valid = 1'b0; if0.bin_in = '0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.bin_in = '0; if1.out_ready = 1'b1;
      if2.in_valid = 1'b0; if2.bin_in = '0; if2.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_in_ready",  32'(if0.in_ready),  32'd1);
      chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
      chk("rst_bcd",       32'(if0.bcd_out),   32'd0);
      chk("rst_ovf",       32'(if0.ovf),       32'd0);

      foreach (tbl[i]) begin
         case (tbl[i].sel)
            0:       conv0(tbl[i].bin, b, o, lat);
            1:       conv1(tbl[i].bin, b, o, lat);
            default: conv2(tbl[i].bin, b, o, lat);
         endcase
         chk($sformatf("vec%0d_bcd", i), b, tbl[i].bcd);
         chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(tbl[i].ovf));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      end

      // backpressure, bin_in changed while busy
      if0.out_ready = 1'b0;
      @(negedge clk);
      if0.in_valid = 1'b1;
      if0.bin_in   = 8'd128;
      @(negedge clk);
      if0.in_valid = 1'b0;
      if0.bin_in   = 8'd77;
      wl = 0;
      while (!if0.out_valid && wl < 100) begin
         @(negedge clk);
         wl++;
         if (wl == 3) chk("bp_busy_rdy", 32'(if0.in_ready), 32'd0);
      end
      chk("bp_lat", 32'(wl), 32'd8);
      for (int k = 0; k < 5; k++) begin
         chk("bp_bcd", 32'(if0.bcd_out), 32'h128);
         chk("bp_valid", 32'(if0.out_valid), 32'd1);
         chk("bp_rdy", 32'(if0.in_ready), 32'd0);
         @(negedge clk);
      end
      if0.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", 32'(if0.out_valid), 32'd0);
      chk("bp_rdy_back", 32'(if0.in_ready), 32'd1);
      chk("bp_hold_idle", 32'(if0.bcd_out), 32'h128);

      // reset in the middle of a conversion
      if0.in_valid = 1'b1;
      if0.bin_in   = 8'd200;
      @(negedge clk);
      if0.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(if0.out_valid), 32'd0);
      chk("mid_rst_bcd", 32'(if0.bcd_out), 32'd0);
      chk("mid_rst_rdy", 32'(if0.in_ready), 32'd1);
      chk("mid_rst_ovf", 32'(if0.ovf), 32'd0);
      conv0(32'd37, b, o, lat);
      chk("post_rst_bcd", b, 32'h037);
      chk("post_rst_lat", 32'(lat), 32'd8);

      // random traffic on the 2-digit instance
      sent = 0;
      got  = 0;
      cyc  = 0;
      drop = 1'b0;
      while (got < 1000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (drop) if2.in_valid = 1'b0;
         drop = 1'b0;
         if (!if2.in_valid && sent < 1000 &&
             $urandom_range(3, 0) != 0) begin
            if2.in_valid = 1'b1;
            if2.bin_in   = 8'($urandom);
         end
         if2.out_ready = 1'($urandom_range(1, 0));
         #1;
         if (if2.in_valid && if2.in_ready) begin
            q.push_back(if2.bin_in);
            sent++;
            drop = 1'b1;
         end
         if (if2.out_valid && if2.out_ready) begin
            got++;
            if (q.size() == 0) begin
               chk("rnd_extra", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               refm(int'(e), 2, eb, eo);
               chk($sformatf("rnd_bcd_%0d", e),
                   32'(if2.bcd_out), eb);
               chk($sformatf("rnd_ovf_%0d", e),
                   32'(if2.ovf), 32'(eo));
            end
         end
      end
      if2.in_valid = 1'b0;
      chk("rnd_count", 32'(got), 32'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
